// File: rtl/data_mem_responder.sv
// Data-memory responder: services one word/byte load or store per
// handshake after WAIT_STATES wait cycles, then strobes a response.
// Ports: clk, reset (async, active-high); request side req_valid,
// req_ready, req_write, req_byte, req_unsigned, req_addr, req_wdata;
// response side resp_valid, resp_rdata, resp_err; busy (not IDLE).
module data_mem_responder #(
  parameter int SIZE_DATA   = 32,
  parameter int ADDR_SIZE   = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic                 req_byte,
  input  logic                 req_unsigned,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [SIZE_DATA-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [SIZE_DATA-1:0] resp_rdata,
  output logic                 resp_err,
  output logic                 busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int HI_LO = IDX_W + 2;
  localparam logic [3:0] WS4 = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t state, state_d;
  logic [3:0] cnt, cnt_d;

  logic [ADDR_SIZE-1:0] addr_q;
  logic [SIZE_DATA-1:0] wdata_q;
  logic                 write_q;
  logic                 byte_q;
  logic                 uns_q;
  logic [SIZE_DATA-1:0] rdata_q;
  logic                 err_q;

  logic [SIZE_DATA-1:0] mem [DEPTH_WORDS];

  logic [IDX_W-1:0]     idx;
  logic [1:0]           lane;
  logic [4:0]           lane_bit;
  logic                 in_range;
  logic                 misal;
  logic                 err;
  logic [SIZE_DATA-1:0] rd_word;
  logic [7:0]           rd_byte;
  logic [SIZE_DATA-1:0] ld_data;
  logic [SIZE_DATA-1:0] wr_word;
  logic                 accept;
  logic                 do_write;

  assign accept = (state == S_IDLE) && req_valid;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          cnt_d   = WS4;
          state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        cnt_d = cnt - 4'd1;
        // counter hits zero on this edge
        if (cnt <= 4'd1) state_d = S_ACCESS;
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      byte_q  <= 1'b0;
      uns_q   <= 1'b0;
    end else if (accept) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      write_q <= req_write;
      byte_q  <= req_byte;
      uns_q   <= req_unsigned;
    end
  end

  assign idx      = addr_q[2 +: IDX_W];
  assign lane     = addr_q[1:0];
  assign lane_bit = {lane, 3'b000};
  assign in_range = ~|addr_q[ADDR_SIZE-1:HI_LO];
  assign misal    = !byte_q && (lane != 2'b00);
  assign err      = !in_range || misal;

  assign rd_word = mem[idx];
  assign rd_byte = rd_word[lane_bit +: 8];

  always_comb begin
    ld_data = rd_word;
    if (byte_q) begin
      ld_data = {{(SIZE_DATA-8){rd_byte[7] & ~uns_q}},
                 rd_byte};
    end
  end

  // byte store merges into the current word
  always_comb begin
    wr_word = wdata_q;
    if (byte_q) begin
      wr_word = rd_word;
      wr_word[lane_bit +: 8] = wdata_q[7:0];
    end
  end

  // reset gating keeps an aborted store out of the array
  assign do_write = (state == S_ACCESS) && write_q &&
                    !err && !reset;

  always_ff @(posedge clk) begin
    if (do_write) mem[idx] <= wr_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state == S_ACCESS) begin
      rdata_q <= (write_q || err) ? '0 : ld_data;
      err_q   <= err;
    end
  end

  assign req_ready  = (state == S_IDLE) && !reset;
  assign resp_valid = (state == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: vector table of
// transactions plus hold-while-busy and mid-transaction reset.
module tb_data_mem_responder;

  localparam int WS    = 2;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_byte;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  always #5 clk = ~clk;

  data_mem_responder #(
    .SIZE_DATA(32),
    .ADDR_SIZE(32),
    .DEPTH_WORDS(DEPTH),
    .WAIT_STATES(WS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_byte(req_byte),
    .req_unsigned(req_unsigned),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .busy(busy)
  );

  typedef struct {
    logic        wr;
    logic        by;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h",
               name, act, exp);
    end
  endtask

  // counts negedges after the accept edge until resp_valid
  task automatic wait_resp(output int n, output bit rdy_bad);
    n = 0;
    rdy_bad = 1'b0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (resp_valid) break;
      if (req_ready) rdy_bad = 1'b1;
    end
  endtask

  task automatic txn(input string name, input vec_t v);
    int  n;
    bit  rb;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, " ready_in"}, 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_write    = v.wr;
    req_byte     = v.by;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    req_addr     = 32'hFFFF_FFFC;
    req_wdata    = 32'h0BAD_0BAD;
    req_unsigned = ~v.uns;
    wait_resp(n, rb);
    chk({name, " latency"}, 32'(n), 32'(WS + 2));
    chk({name, " ready_busy"}, 32'(rb), 32'd0);
    chk({name, " rdata"}, resp_rdata, v.exp_rdata);
    chk({name, " err"}, 32'(resp_err), 32'(v.exp_err));
    @(negedge clk);
    chk({name, " one_shot"}, 32'(resp_valid), 32'd0);
    chk({name, " ready_out"}, 32'(req_ready), 32'd1);
  endtask

  vec_t tab [14];

  initial begin
    int  n;
    bit  rb;
    int  seen;
    vec_t v;

    //            wr  by  uns addr         wdata         rdata         err
    tab[0]  = '{1'b1,1'b0,1'b0,32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
    tab[1]  = '{1'b0,1'b0,1'b0,32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    tab[2]  = '{1'b0,1'b1,1'b0,32'h13,  32'h0,        32'hFFFFFFDE, 1'b0};
    tab[3]  = '{1'b0,1'b1,1'b1,32'h13,  32'h0,        32'h000000DE, 1'b0};
    tab[4]  = '{1'b1,1'b1,1'b0,32'h11,  32'hAAAAAA55, 32'h0,        1'b0};
    tab[5]  = '{1'b0,1'b0,1'b0,32'h10,  32'h0,        32'hDEAD55EF, 1'b0};
    tab[6]  = '{1'b0,1'b0,1'b0,32'h12,  32'h0,        32'h0,        1'b1};
    tab[7]  = '{1'b1,1'b0,1'b0,32'h0,   32'h12345678, 32'h0,        1'b0};
    tab[8]  = '{1'b1,1'b0,1'b0,32'h400, 32'hFFFFFFFF, 32'h0,        1'b1};
    tab[9]  = '{1'b0,1'b0,1'b0,32'h0,   32'h0,        32'h12345678, 1'b0};
    tab[10] = '{1'b0,1'b1,1'b0,32'h12,  32'h0,        32'hFFFFFFAD, 1'b0};
    tab[11] = '{1'b0,1'b1,1'b1,32'h11,  32'h0,        32'h00000055, 1'b0};
    tab[12] = '{1'b1,1'b1,1'b0,32'h403, 32'h80,       32'h0,        1'b1};
    tab[13] = '{1'b1,1'b0,1'b0,32'h44,  32'h11111111, 32'h0,        1'b0};

    reset        = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_byte     = 1'b0;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;

    repeat (2) @(negedge clk);
    chk("rst ready", 32'(req_ready), 32'd0);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst rdata", resp_rdata, 32'd0);
    chk("rst err", 32'(resp_err), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 14; i++) begin
      txn($sformatf("v%0d", i), tab[i]);
    end

    // request held through a busy window with changing fields
    @(negedge clk);
    chk("hold ready0", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_byte  = 1'b0;
    req_addr  = 32'h30;
    req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    req_addr  = 32'h44;
    req_wdata = 32'h0BADBEEF;
    @(negedge clk);
    chk("hold busy", 32'(busy), 32'd1);
    req_addr  = 32'h40;
    req_wdata = 32'h600DF00D;
    n = 1;
    rb = 1'b0;
    while (n < 40 && !resp_valid) begin
      @(negedge clk);
      n++;
      if (!resp_valid && req_ready) rb = 1'b1;
    end
    chk("hold lat1", 32'(n), 32'(WS + 2));
    chk("hold ready_busy1", 32'(rb), 32'd0);
    @(negedge clk);
    chk("hold ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_resp(n, rb);
    chk("hold lat2", 32'(n), 32'(WS + 2));
    chk("hold err2", 32'(resp_err), 32'd0);

    v = '{1'b0,1'b0,1'b0,32'h30,32'h0,32'hCAFEF00D,1'b0};
    txn("hold rd30", v);
    v = '{1'b0,1'b0,1'b0,32'h40,32'h0,32'h600DF00D,1'b0};
    txn("hold rd40", v);
    v = '{1'b0,1'b0,1'b0,32'h44,32'h0,32'h11111111,1'b0};
    txn("hold rd44", v);

    // reset during WAIT of a store
    v = '{1'b1,1'b0,1'b0,32'h20,32'h0,32'h0,1'b0};
    txn("rst_mid init", v);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_byte  = 1'b0;
    req_addr  = 32'h20;
    req_wdata = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid ready", 32'(req_ready), 32'd0);
    chk("rst_mid idle", 32'(busy), 32'd0);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid ready_after", 32'(req_ready), 32'd1);
    repeat (6) begin
      if (resp_valid) seen++;
      @(negedge clk);
    end
    chk("rst_mid no_resp", 32'(seen), 32'd0);
    v = '{1'b0,1'b0,1'b0,32'h20,32'h0,32'h0,1'b0};
    txn("rst_mid rd20", v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
